mem_responder: RTL and testbench

Behavioural-synthesisable memory responder for the MemBus request/response protocol used by the cache. It is the far end of the protocol that a bus initiator (cache controller or testbench driver) talks to. It accepts one read or write per cycle, holds a flat word-addressed array, and returns read data with a fixed, configurable latency. It serves as the backing store beneath the cache and as a golden responder for protocol-level benches.

---
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: behavioural memory responder for the MemBus request/response
// protocol. Holds a flat word-addressed array, accepts one READ or WRITE per
// cycle without backpressure, and returns read data after a fixed LATENCY.
//
// Optional feature macro: MEM_CLEAR_EN
//   defined   -> after reset a CLEAR sweep writes 0 to every word, one address
//                per cycle, while busy is high and requests are dropped.
//   undefined -> no sweep; busy is tied 0 and unwritten words are undefined.
//
// Parameters:
//   ADDR_WIDTH  word-address width (array holds 2**ADDR_WIDTH words)
//   DATA_WIDTH  word width
//   LATENCY     request-to-response cycles, legal range 1..16
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (clears control, not the array)
//   req_op    0 = INVALID, 1 = READ, 2 = WRITE, 3 = treated as INVALID
//   req_addr  word address, sampled on READ/WRITE
//   req_data  write data, sampled on WRITE
//   rsp_vld   one-cycle pulse per accepted read
//   rsp_data  read data; holds its last value between pulses
//   busy      high while requests are ignored (clear sweep in progress)
module mem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [LATENCY-1:0]    vld_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  out_en;
  logic [DATA_WIDTH-1:0] out_in;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  busy_int;

`ifdef MEM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic                  busy_q;

  // Sweep FSM: one zero-write per cycle; leaves CLEAR on the edge that
  // writes the last address and never returns except through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + ADDR_ONE;
          if (&clr_addr_q) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_READY;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_int = busy_q;
  assign clr_we   = !rst && (state_q == ST_CLEAR);
  assign clr_addr = clr_addr_q;
`else
  assign busy_int = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign busy = busy_int;

  // Requests presented while reset is held are never accepted.
  assign accept = !rst && !busy_int;
  assign rd_acc = accept && (req_op == OP_READ);
  assign wr_acc = accept && (req_op == OP_WRITE);

  // Only one op per cycle, so a write at edge N is already in the array when
  // a read at edge N+1 samples it; no bypass path is needed.
  assign rd_word = mem_q[req_addr];

  // Array: not reset; the sweep (when compiled in) has priority over requests.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem_q[req_addr] <= req_data;
    end
  end

  // Valid pipeline: advances every cycle, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Data pipeline: each stage loads only when the word entering it is valid,
  // which lets the output register hold its last value between responses.
  if (LATENCY == 1) begin : g_nomid
    assign out_en = rd_acc;
    assign out_in = rd_word;
  end else begin : g_mid
    logic [DATA_WIDTH-1:0] dat_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (rd_acc) begin
        dat_q[0] <= rd_word;
      end
      for (int i = 1; i < LATENCY - 1; i++) begin
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign out_en = vld_q[LATENCY-2];
    assign out_in = dat_q[LATENCY-2];
  end

  // Output stage: reset to 0, otherwise updated only by a valid word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q <= '0;
    end else if (out_en) begin
      rsp_data_q <= out_in;
    end
  end

  assign rsp_vld  = vld_q[LATENCY-1];
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder (ADDR_WIDTH=6,
// DATA_WIDTH=32, LATENCY=4). A behavioural model (array + queue of pending
// responses with due cycles) is compared with the DUT on every cycle, and
// directed scenarios pin the model with hand-computed literals. Scenarios that
// depend on the clear sweep are compiled when MEM_CLEAR_EN is defined.
module tb_mem_responder;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int L     = 4;
  localparam int DEPTH = 64;
  localparam logic [1:0] OP_INV = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_BAD = 2'd3;
`ifdef MEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_op = OP_INV;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_vld;
  logic [DW-1:0] rsp_data;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(L)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_op  (req_op),
    .req_addr(req_addr),
    .req_data(req_data),
    .rsp_vld (rsp_vld),
    .rsp_data(rsp_data),
    .busy    (busy)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            known;
  } exp_t;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  exp_t          pend [$];
  int            clr_left = 0;
  logic [DW-1:0] hold_data = '0;
  bit            hold_known = 1'b1;
  int            log_cyc [$];
  logic [DW-1:0] log_data [$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update at each edge, then compare 1 time unit later.
  always begin
    exp_t e;
    bit   exp_v;
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
      hold_data  = '0;
      hold_known = 1'b1;
      clr_left   = CLR ? DEPTH : 0;
    end else if (clr_left > 0) begin
      m_mem[DEPTH-clr_left]   = '0;
      m_known[DEPTH-clr_left] = 1'b1;
      clr_left--;
    end else if (req_op == OP_WR) begin
      m_mem[req_addr]   = req_data;
      m_known[req_addr] = 1'b1;
    end else if (req_op == OP_RD) begin
      pend.push_back('{due: cyc + L - 1, data: m_mem[req_addr], known: m_known[req_addr]});
    end
    #1;
    exp_v = (pend.size() > 0) && (pend[0].due == cyc);
    check("rsp_vld", {63'd0, rsp_vld}, {63'd0, exp_v});
    if (exp_v) begin
      e = pend.pop_front();
      if (e.known) check("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
      hold_data  = e.data;
      hold_known = e.known;
    end else if (hold_known) begin
      check("rsp_data_hold", {32'd0, rsp_data}, {32'd0, hold_data});
    end
    check("busy", {63'd0, busy}, {63'd0, (clr_left > 0)});
    if (rsp_vld) begin
      log_cyc.push_back(cyc);
      log_data.push_back(rsp_data);
    end
  end

  task automatic drive(logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] d);
    @(negedge clk);
    req_op   = op;
    req_addr = a;
    req_data = d;
  endtask

  task automatic idle(int n);
    repeat (n) drive(OP_INV, '0, '0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 200) begin
      drive(OP_INV, '0, '0);
      n++;
    end
    check("ready_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic expect_log(string name, int idx, int exp_cyc, logic [DW-1:0] exp_d);
    if (idx >= log_data.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: no response #%0d seen, expected 0x%0h at cycle %0d", name, idx, exp_d, exp_cyc);
    end else begin
      check({name, "_data"}, {32'd0, log_data[idx]}, {32'd0, exp_d});
      check({name, "_cycle"}, 64'(log_cyc[idx]), 64'(exp_cyc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0;
    int rd_issued;
    int r;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rsp_vld", {63'd0, rsp_vld}, 64'd0);
    check("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
    check("reset_busy", {63'd0, busy}, {63'd0, CLR});
    rst = 1'b0;
`ifdef MEM_CLEAR_EN
    drive(OP_WR, 6'h07, 32'h1);
    wait_ready();
    log_cyc.delete(); log_data.delete();
    drive(OP_RD, 6'h07, '0); e0 = cyc + 1;
    idle(L + 2);
    expect_log("clear_drop", 0, e0 + L - 1, 32'h0);
`else
    wait_ready();
`endif

    // Write then read
    log_cyc.delete(); log_data.delete();
    drive(OP_WR, 6'h05, 32'hDEADBEEF);
    drive(OP_RD, 6'h05, '0); e0 = cyc + 1;
    idle(L + 2);
    expect_log("wr_rd", 0, e0 + L - 1, 32'hDEADBEEF);
    check("wr_rd_count", 64'(log_data.size()), 64'd1);

    // Back-to-back reads
    log_cyc.delete(); log_data.delete();
    drive(OP_WR, 6'h01, 32'h11);
    drive(OP_WR, 6'h02, 32'h22);
    drive(OP_RD, 6'h01, '0); e0 = cyc + 1;
    drive(OP_RD, 6'h02, '0);
    idle(L + 2);
    expect_log("b2b_first", 0, e0 + L - 1, 32'h11);
    expect_log("b2b_second", 1, e0 + L, 32'h22);
    check("b2b_count", 64'(log_data.size()), 64'd2);

    // Idle and invalid encodings must neither respond nor write
    log_cyc.delete(); log_data.delete();
    repeat (5) drive(OP_INV, 6'h05, 32'h12345678);
    repeat (5) drive(OP_BAD, 6'h05, 32'hCAFEF00D);
    idle(L);
    check("invalid_no_rsp", 64'(log_data.size()), 64'd0);
    drive(OP_RD, 6'h05, '0); e0 = cyc + 1;
    idle(L + 2);
    expect_log("invalid_mem_kept", 0, e0 + L - 1, 32'hDEADBEEF);

    // Reset mid-flight: the in-flight read must never be answered
    log_cyc.delete(); log_data.delete();
    drive(OP_RD, 6'h05, '0);
    drive(OP_INV, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_vld", {63'd0, rsp_vld}, 64'd0);
    check("rst_async_data", {32'd0, rsp_data}, 64'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_data", {32'd0, rsp_data}, 64'd0);
    rst = 1'b0;
    idle(L + 2);
    check("rst_discard", 64'(log_data.size()), 64'd0);
    wait_ready();

    // Randomised sweep against the model
    for (int a = 0; a < DEPTH; a++) drive(OP_WR, AW'(a), $urandom);
    log_cyc.delete(); log_data.delete();
    rd_issued = 0;
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        drive(OP_RD, AW'($urandom_range(0, DEPTH - 1)), $urandom);
        rd_issued++;
      end else if (r < 8) begin
        drive(OP_WR, AW'($urandom_range(0, DEPTH - 1)), $urandom);
      end else begin
        drive((r == 8) ? OP_INV : OP_BAD, AW'($urandom_range(0, DEPTH - 1)), $urandom);
      end
    end
    idle(L + 2);
    check("rand_rsp_count", 64'(log_data.size()), 64'(rd_issued));
    check("rand_pending_empty", 64'(pend.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
